// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer between two bus masters and the
// shared memory bus; drives the active-low strobes and captures read data.
module mem_bus_arbiter #(
  parameter int unsigned DATA_W   = 256,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] address,
  output logic              nRead,
  output logic              nWrite,
  output logic [DATA_W-1:0] BusDataOut,
  input  logic [DATA_W-1:0] BusDataIn
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_e;

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               own_q, own_d;
  logic               we_q, we_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [1:0]         done_q, done_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [ADDR_W-1:0]  address_q, address_d;
  logic [DATA_W-1:0]  bdo_q, bdo_d;
  logic               nrd_q, nrd_d;
  logic               nwr_q, nwr_d;

  logic               any_req_c;
  logic               win_c;
  logic               win_we_c;
  logic [ADDR_W-1:0]  win_addr_c;
  logic [DATA_W-1:0]  win_wdata_c;

  // On a tie the master not served last wins; ptr_q holds the last-served index.
  always_comb begin
    any_req_c   = req0 | req1;
    win_c       = (req0 & req1) ? ~ptr_q : req1;
    win_we_c    = win_c ? we1 : we0;
    win_addr_c  = win_c ? addr1 : addr0;
    win_wdata_c = win_c ? wdata1 : wdata0;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= S_IDLE;
      ptr_q     <= 1'b1;
      own_q     <= 1'b0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      address_q <= '0;
      bdo_q     <= '0;
      nrd_q     <= 1'b1;
      nwr_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      own_q     <= own_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      address_q <= address_d;
      bdo_q     <= bdo_d;
      nrd_q     <= nrd_d;
      nwr_q     <= nwr_d;
    end
  end

  // Next state plus next registered bus outputs; strobes default to inactive.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    own_d     = own_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    rdata_d   = rdata_q;
    address_d = address_q;
    bdo_d     = bdo_q;
    nrd_d     = 1'b1;
    nwr_d     = 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (any_req_c) begin
          state_d   = S_ISSUE;
          own_d     = win_c;
          we_d      = win_we_c;
          cnt_d     = '0;
          gnt_d     = win_c ? 2'b10 : 2'b01;
          address_d = win_addr_c;
          bdo_d     = win_wdata_c;
          nwr_d     = ~win_we_c;
          nrd_d     = win_we_c;
        end else begin
          state_d   = S_IDLE;
          gnt_d     = '0;
          address_d = '0;
          bdo_d     = '0;
        end
      end
      S_ISSUE: begin
        if (we_q || (cnt_q == CNT_W'(READ_LAT - 1))) begin
          state_d = S_DONE;
          ptr_d   = own_q;
          done_d  = own_q ? 2'b10 : 2'b01;
          if (!we_q) begin
            rdata_d = BusDataIn;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          nrd_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign gnt0       = gnt_q[0];
  assign gnt1       = gnt_q[1];
  assign done0      = done_q[0];
  assign done1      = done_q[1];
  assign rdata      = rdata_q;
  assign address    = address_q;
  assign BusDataOut = bdo_q;
  assign nRead      = nrd_q;
  assign nWrite     = nwr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a transaction-level model predicts grant
// order, timing and read data; a negedge monitor compares every bus cycle.
module tb_mem_bus_arbiter;

  localparam int unsigned DATA_W   = 256;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned READ_LAT = 3;

  logic              Clk = 1'b0;
  logic              nReset;
  logic              m_req [2];
  logic              m_we [2];
  logic [ADDR_W-1:0] m_addr [2];
  logic [DATA_W-1:0] m_wdata [2];
  logic              gnt0, gnt1, done0, done1, nRead, nWrite;
  logic [DATA_W-1:0] rdata, BusDataOut;
  logic [DATA_W-1:0] BusDataIn = '0;
  logic [ADDR_W-1:0] address;

  mem_bus_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
    .Clk(Clk), .nReset(nReset),
    .req0(m_req[0]), .req1(m_req[1]), .we0(m_we[0]), .we1(m_we[1]),
    .addr0(m_addr[0]), .addr1(m_addr[1]), .wdata0(m_wdata[0]), .wdata1(m_wdata[1]),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata),
    .address(address), .nRead(nRead), .nWrite(nWrite),
    .BusDataOut(BusDataOut), .BusDataIn(BusDataIn)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int                m;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    int                start;
    int                fin;
  } txn_t;

  txn_t              sb [$];
  logic [DATA_W-1:0] slave_mem [16];
  logic [DATA_W-1:0] ref_mem [16];
  logic [DATA_W-1:0] exp_rdata = '0;
  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;

  // Master/model bookkeeping, owned by the stimulus process
  logic              pend [2];
  logic              granted [2];
  int                done_at [2];
  logic              t_we [2];
  logic [ADDR_W-1:0] t_addr [2];
  logic [DATA_W-1:0] t_wdata [2];
  int                free_cyc = 0;
  int                last = 1;

  always @(posedge Clk) cyc <= cyc + 1;

  // Negedge-clocked slave: 16 words, low address bits select the word
  always @(negedge Clk) begin
    if (!nRead) BusDataIn <= slave_mem[address[3:0]];
    if (!nWrite) slave_mem[address[3:0]] <= BusDataOut;
  end

  task automatic check(string name, logic [DATA_W-1:0] got, logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(DATA_W / 32); i++) r = {r[DATA_W-33:0], 32'($urandom)};
    return r;
  endfunction

  // Monitor: compare the bus against the oldest outstanding predicted transaction
  always @(negedge Clk) begin
    logic [1:0]        g_e, d_e;
    logic              nr_e, nw_e, chk_bus;
    logic [ADDR_W-1:0] a_e;
    logic [DATA_W-1:0] b_e;
    if (!nReset) begin
      exp_rdata = '0;
      check("rst_gnt", DATA_W'({gnt1, gnt0}), '0);
      check("rst_done", DATA_W'({done1, done0}), '0);
      check("rst_strobes", DATA_W'({nRead, nWrite}), DATA_W'(2'b11));
      check("rst_address", DATA_W'(address), '0);
      check("rst_busdataout", BusDataOut, '0);
      check("rst_rdata", rdata, '0);
    end else begin
      g_e = '0; d_e = '0; nr_e = 1'b1; nw_e = 1'b1; a_e = '0; b_e = '0; chk_bus = 1'b1;
      if (sb.size() > 0 && cyc >= sb[0].start) begin
        g_e[sb[0].m] = 1'b1;
        if (cyc < sb[0].fin) begin
          nr_e = sb[0].we;
          nw_e = ~sb[0].we;
          a_e  = sb[0].addr;
          b_e  = sb[0].wdata;
        end else begin
          d_e[sb[0].m] = 1'b1;
          chk_bus = 1'b0;
          if (!sb[0].we) exp_rdata = sb[0].rdata;
          void'(sb.pop_front());
        end
      end
      check("gnt", DATA_W'({gnt1, gnt0}), DATA_W'(g_e));
      check("done", DATA_W'({done1, done0}), DATA_W'(d_e));
      check("nRead", DATA_W'(nRead), DATA_W'(nr_e));
      check("nWrite", DATA_W'(nWrite), DATA_W'(nw_e));
      check("rdata", rdata, exp_rdata);
      if (chk_bus) begin
        check("address", DATA_W'(address), DATA_W'(a_e));
        check("busdataout", BusDataOut, b_e);
      end
    end
  end

  // Drive both masters for this cycle, then let the model arbitrate at the coming edge
  task automatic drive_and_model(int unsigned p_req);
    txn_t e;
    int   win, lat;
    logic w0, w1;
    for (int m = 0; m < 2; m++) begin
      if (granted[m] && done_at[m] == cyc) begin
        granted[m] = 1'b0;
        pend[m]    = 1'b0;
      end
      if (!pend[m] && $urandom_range(99) < p_req) begin
        pend[m]    = 1'b1;
        t_we[m]    = 1'($urandom_range(1));
        t_addr[m]  = ADDR_W'($urandom_range(15));
        t_wdata[m] = rand_data();
      end
      if (pend[m] && !granted[m]) begin
        m_req[m] = 1'b1; m_we[m] = t_we[m]; m_addr[m] = t_addr[m]; m_wdata[m] = t_wdata[m];
      end else begin
        m_req[m]   = granted[m];
        m_we[m]    = 1'($urandom_range(1));
        m_addr[m]  = ADDR_W'($urandom);
        m_wdata[m] = rand_data();
      end
    end
    if (cyc >= free_cyc) begin
      w0 = pend[0] && !granted[0];
      w1 = pend[1] && !granted[1];
      if (w0 || w1) begin
        win     = (w0 && w1) ? 1 - last : (w1 ? 1 : 0);
        lat     = t_we[win] ? 1 : int'(READ_LAT);
        e.m     = win;
        e.we    = t_we[win];
        e.addr  = t_addr[win];
        e.wdata = t_wdata[win];
        e.rdata = '0;
        if (t_we[win]) ref_mem[t_addr[win][3:0]] = t_wdata[win];
        else e.rdata = ref_mem[t_addr[win][3:0]];
        e.start = cyc + 1;
        e.fin   = cyc + lat + 1;
        sb.push_back(e);
        granted[win] = 1'b1;
        done_at[win] = e.fin;
        last         = win;
        free_cyc     = e.fin;
      end else begin
        free_cyc = cyc + 1;
      end
    end
  endtask

  task automatic tick(int unsigned p_req);
    @(negedge Clk);
    #1;
    drive_and_model(p_req);
  endtask

  task automatic post(int m, logic we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    pend[m] = 1'b1; t_we[m] = we; t_addr[m] = a; t_wdata[m] = d;
  endtask

  task automatic run_until_idle(string name);
    int guard;
    guard = 0;
    while ((pend[0] || pend[1]) && guard < 200) begin
      tick(0);
      guard++;
    end
    check(name, DATA_W'(pend[0] || pend[1]), '0);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = rand_data();
      ref_mem[i]   = slave_mem[i];
    end
    slave_mem[8] = DATA_W'(32'h04);  ref_mem[8] = DATA_W'(32'h04);
    slave_mem[9] = DATA_W'(32'h11);  ref_mem[9] = DATA_W'(32'h11);
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; granted[m] = 1'b0; done_at[m] = -1;
      m_req[m] = 1'b0; m_we[m] = 1'b0; m_addr[m] = '0; m_wdata[m] = '0;
      t_we[m] = 1'b0; t_addr[m] = '0; t_wdata[m] = '0;
    end
    nReset = 1'b1;
    #1 nReset = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    nReset   = 1'b1;
    free_cyc = cyc;
    last     = 1;

    // Directed: single read by master 1, write/read-back, latency-3 read
    post(1, 1'b0, ADDR_W'(16'h0008), '0);
    run_until_idle("idle_after_m1_read8");
    post(0, 1'b1, ADDR_W'(16'h0002), DATA_W'(32'hABCD));
    run_until_idle("idle_after_m0_write2");
    post(1, 1'b0, ADDR_W'(16'h0002), '0);
    run_until_idle("idle_after_m1_read2");
    post(1, 1'b0, ADDR_W'(16'h0009), '0);
    run_until_idle("idle_after_m1_read9");

    // Both masters requesting continuously: strict alternation, no idle gap
    post(0, 1'($urandom_range(1)), ADDR_W'($urandom_range(15)), rand_data());
    post(1, 1'($urandom_range(1)), ADDR_W'($urandom_range(15)), rand_data());
    repeat (40) tick(100);
    run_until_idle("idle_after_saturation");

    repeat (2500) tick(35);
    run_until_idle("idle_after_random");

    // Reset in the middle of a read after master 0 was served last
    post(0, 1'b1, ADDR_W'(16'h0003), rand_data());
    run_until_idle("idle_after_pre_reset_write");
    post(0, 1'b0, ADDR_W'(16'h0009), '0);
    guard = 0;
    while (!(sb.size() > 0 && cyc == sb[0].start + 1) && guard < 50) begin
      tick(0);
      guard++;
    end
    check("reach_mid_issue", DATA_W'(guard < 50), DATA_W'(1'b1));
    nReset = 1'b0;
    #1;
    check("async_rst_gnt", DATA_W'({gnt1, gnt0}), '0);
    check("async_rst_nRead", DATA_W'(nRead), DATA_W'(1'b1));
    check("async_rst_address", DATA_W'(address), '0);
    sb.delete();
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; granted[m] = 1'b0; done_at[m] = -1; m_req[m] = 1'b0;
    end
    last = 1;
    repeat (2) @(negedge Clk);
    #1;
    post(0, 1'b0, ADDR_W'(16'h0008), '0);
    post(1, 1'b0, ADDR_W'(16'h0009), '0);
    nReset   = 1'b1;
    free_cyc = cyc;
    drive_and_model(0);
    run_until_idle("idle_after_reset_tie");
    repeat (3) tick(0);

    check("scoreboard_empty", DATA_W'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Round-robin arbiter and transaction sequencer for the shared memory-mapped bus (address, nRead, nWrite, 256-bit write data, 256-bit read data). It sits between two bus masters and the bus. Master 0 is the instruction/control fetch path; master 1 is the execute unit. Each master gets exclusive, single-transaction access. The arbiter generates the active-low strobes and captures read data from the negedge-clocked bus slaves.

## Interface
Parameters:
- DATA_W, 256, bus data width
- ADDR_W, 16, bus address width; [15:12] selects the slave, decoded by the slaves, not here
- READ_LAT, 1, rising edges the read strobe is held before data is captured (1..15)

Ports:
- Clk  input  1  system clock; arbiter state changes on the rising edge
- nReset  input  1  reset nReset, asynchronous, active-low
- req0 / req1  input  1  transaction request from master 0 / 1
- we0 / we1  input  1  1 = write, 0 = read
- addr0 / addr1  input  ADDR_W  transaction address
- wdata0 / wdata1  input  DATA_W  write data
- gnt0 / gnt1  output  1  master owns the bus (ISSUE and DONE states)
- done0 / done1  output  1  one-cycle completion pulse
- rdata  output  DATA_W  last captured read data, shared by both masters
- address  output  ADDR_W  bus address
- nRead / nWrite  output  1  active-low bus strobes
- BusDataOut  output  DATA_W  bus write data
- BusDataIn  input  DATA_W  bus read data; slaves update it on the falling edge

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Any req high at the rising edge: latch the winner's addr, we and wdata, then go to ISSUE.
- Arbitration:
  - Single requester wins.
  - Both requesting: the master not served last wins.
  - The last-served pointer resets to 1, so master 0 wins the first tie.
- ISSUE:
  - address and BusDataOut show the latched values; gntN=1.
  - Write: nWrite=0 for exactly 1 cycle, then DONE.
  - Read: nRead=0 for READ_LAT cycles. rdata <= BusDataIn at the last ISSUE rising edge, then DONE.
  - nRead and nWrite are never low together.
- DONE:
  - gntN=1 and doneN=1 for one cycle; strobes high.
  - The pointer updates to N.
  - Arbitration runs again here. If either req is high at the DONE edge, go directly to ISSUE for the winner; otherwise go to IDLE.
- Master rules:
  - addr, we and wdata are latched at grant; changes after grant are ignored.
  - A master must drop req in its done cycle, or keep it high to request a new transaction.
  - req high at the DONE edge is a new request.
- rdata holds its value until the next read capture; writes do not modify it.
- Idle bus: address=0, BusDataOut=0, nRead=nWrite=1.
- Reset:
  - Asserting nReset at any time, including mid-ISSUE, forces IDLE, pointer=1 and all outputs to reset values.
  - The abandoned transaction gets no done pulse.
- Reset values: gnt0=gnt1=0, done0=done1=0, rdata=0, address=0, BusDataOut=0, nRead=1, nWrite=1.

## Timing
- Cycle k: req sampled at the rising edge ending IDLE.
- Cycle k+1: ISSUE; strobe low; the slave acts at the falling edge within this cycle.
- Write latency: done in cycle k+2; 2 cycles from req to done.
- Read latency: captured at the end of cycle k+READ_LAT; done in cycle k+READ_LAT+1.
- Back-to-back throughput: one transaction per READ_LAT+1 cycles for reads, 2 cycles for writes.
- Starvation bound: with both masters requesting continuously, grants alternate 0,1,0,1.
- All outputs are registered; none depend combinationally on req.

## Test plan
- Reset, then master 1 reads address 0x0008 from a slave holding 0x04 at word 8 (READ_LAT=1): nRead low for exactly 1 cycle -> done1 two cycles after req, rdata=0x04, gnt0 never high.
- Master 0 writes 0xABCD to 0x0002, then master 1 reads 0x0002 -> nWrite low for 1 cycle, rdata=0xABCD, rdata unchanged during the write.
- Both req rise in the same cycle after reset and stay high for 4 transactions -> grant order 0,1,0,1; no IDLE cycle between them; strobes never low together.
- READ_LAT=3, read 0x0009 with the slave holding 0x11 -> nRead low for 3 cycles, done at req+4, rdata=0x11.
- nReset pulsed low during a read's ISSUE -> no done pulse; all outputs at reset values; after release, a tie grants master 0.
- Master 1 changes addr1 from 0x0008 to 0x0009 after grant -> address stays 0x0008 and rdata=0x04.
